// File: rtl/actfunc_pkg.sv
// Shared fixed-point helpers for the activation forward/backward units.
// Q-format constants and the common shift/round function live here.
package actfunc_pkg;

  localparam int ACT_WIDTH = 16;
  localparam int ACT_FP    = 12;
  localparam int FP_ONE    = 1 << ACT_FP;
  localparam int FP_HALF   = 1 << (ACT_FP - 1);

  // Arithmetic right shift by sh; with rnd set, add half an LSB first so the
  // result rounds to nearest with ties going toward +inf.
  function automatic logic signed [63:0] fx_shr(input logic signed [63:0] x,
                                                 input int sh,
                                                 input bit rnd);
    logic signed [63:0] bias;
    bias = rnd ? (64'sd1 <<< (sh - 1)) : 64'sd0;
    return (x + bias) >>> sh;
  endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// Signed multiply followed by a fixed-point shift/round, result registered.
// One pipeline stage; holds its output while en is low.
module fx_mul_shift
  import actfunc_pkg::*;
#(
  parameter int AW  = 17,
  parameter int BW  = 17,
  parameter int OW  = 16,
  parameter int SH  = 12,
  parameter bit RND = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [OW-1:0] q
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] prod;
  logic signed [63:0]   shifted;

  // Full-precision product, then scale back into the output Q format.
  always_comb begin
    prod    = PW'(a) * PW'(b);
    shifted = fx_shr(64'(prod), SH, RND);
  end

  // Result register; upper bits beyond OW are known to be sign copies.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= OW'(shifted);
  end

endmodule

// File: rtl/sigmoid_bwd.sv
// Sigmoid backward pass: dx = g * y * (1 - y), 3-stage valid/ready pipeline.
// S1 clamps y to 1.0, S2 forms d = y(1-y), S3 forms dx = g*d.
// Build option: define SIGMOID_BWD_RND_EN to round both shifts to nearest
// instead of truncating (floor).
module sigmoid_bwd
  import actfunc_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH,
  parameter int FP    = ACT_FP,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_g,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dx,
  output logic [TAGW-1:0]  out_tag
);

  localparam int STAGES = 3;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FP;

`ifdef SIGMOID_BWD_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] g;
    logic [TAGW-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [TAGW-1:0]  tag;
  } s2_t;

  logic [STAGES:1]   vld_pipe;
  logic              adv;
  logic              acc;
  logic [WIDTH-1:0]  y_c;
  logic [WIDTH-1:0]  one_minus_y;
  logic [WIDTH-1:0]  d2;
  logic signed [WIDTH-1:0] dx3;
  s1_t               s1;
  s2_t               s2;
  logic [TAGW-1:0]   tag3;

  // Whole pipe moves in lockstep; only a stalled S3 can block it.
  assign adv      = !vld_pipe[STAGES] || out_ready;
  assign in_ready = adv && !rst;
  assign acc      = in_valid && in_ready;

  // Activations above 1.0 would make (1 - y) negative; pin them to 1.0.
  assign y_c         = (in_y > ONE) ? ONE : in_y;
  assign one_minus_y = ONE - s1.y;

  // Valid shift register; bubbles advance like real samples.
  always_ff @(posedge clk) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], acc};
  end

  // Sideband and operand registers travelling with the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      tag3 <= '0;
    end else if (adv) begin
      s1   <= '{y: y_c, g: in_g, tag: in_tag};
      s2   <= '{g: s1.g, tag: s1.tag};
      tag3 <= s2.tag;
    end
  end

  // S2: d = y(1-y); both operands are non-negative, zero-extended.
  fx_mul_shift #(
    .AW(WIDTH + 1), .BW(WIDTH + 1), .OW(WIDTH), .SH(FP), .RND(RND)
  ) u_d (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .a   ($signed({1'b0, s1.y})),
    .b   ($signed({1'b0, one_minus_y})),
    .q   (d2)
  );

  // S3: dx = g*d; d <= 0.25 so the result always fits WIDTH bits.
  fx_mul_shift #(
    .AW(WIDTH), .BW(WIDTH + 1), .OW(WIDTH), .SH(FP), .RND(RND)
  ) u_dx (
    .clk (clk),
    .rst (rst),
    .en  (adv),
    .a   ($signed(s2.g)),
    .b   ($signed({1'b0, d2})),
    .q   (dx3)
  );

  assign out_valid = vld_pipe[STAGES];
  assign out_dx    = dx3;
  assign out_tag   = tag3;

endmodule

// File: tb/tb_sigmoid_bwd.sv
// Directed self-checking bench for sigmoid_bwd.
module tb_sigmoid_bwd;

  localparam int N = 10;

`ifdef SIGMOID_BWD_RND_EN
  localparam int RND_E = 1;
`else
  localparam int RND_E = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_y = '0;
  logic [15:0] in_g = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_dx;
  logic [3:0]  out_tag;

  int n_chk = 0;
  int n_err = 0;

  // Hand-computed vectors: y, g, expected dx.
  int ty[N] = '{2048, 0,    4096, 5000, 2048,  1000,  1000, 2048, 3072, 1024};
  int tg[N] = '{4096, 4096, 4096, 4096, -4096, 3,     -3,   100,  4096, -2048};
  int te[N] = '{1024, 0,    0,    0,    -1024, RND_E, -1,   25,   768,  -384};

  sigmoid_bwd #(.WIDTH(16), .FP(12), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_g      (in_g),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dx    (out_dx),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tag_of(input int i);
    return 4'((i * 3 + 1) & 15);
  endfunction

  initial begin
    int tx, rx, c, seen;

    // Reset state, inputs and outputs sampled on the falling edge.
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dx", $signed(out_dx), 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Single sample: captured at the next edge, valid after the third edge.
    in_valid = 1'b1; in_y = 16'd2048; in_g = 16'd4096; in_tag = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_edge1", out_valid, 0);
    @(negedge clk);
    check("lat_edge2", out_valid, 0);
    @(negedge clk);
    check("lat_edge3_valid", out_valid, 1);
    check("lat_dx", $signed(out_dx), 1024);
    check("lat_tag", out_tag, 5);
    @(negedge clk);
    check("lat_drained", out_valid, 0);

    // Stream all vectors; out_ready held low for the first 5 cycles.
    tx = 0; rx = 0; c = 0;
    while (rx < N && c < 300) begin
      out_ready = (c >= 5);
      if (tx < N) begin
        in_valid = 1'b1;
        in_y     = 16'(ty[tx]);
        in_g     = 16'(tg[tx]);
        in_tag   = tag_of(tx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 3 || c == 4) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_accepts", tx, 3);
        check("stall_hold_dx", $signed(out_dx), te[0]);
        check("stall_hold_tag", out_tag, tag_of(0));
      end
      if (out_valid && out_ready) begin
        check("stream_dx", $signed(out_dx), te[rx]);
        check("stream_tag", out_tag, tag_of(rx));
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    check("stream_count", rx, N);

    // Fill the pipe under backpressure, then reset it mid-flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_y = 16'd2048; in_g = 16'd4096; in_tag = 4'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("prerst_full", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_dx", $signed(out_dx), 0);
    check("midrst_tag", out_tag, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_ghosts", seen, 0);

    // Pipe works normally after the mid-flight reset.
    in_valid = 1'b1; in_y = 16'd3072; in_g = 16'd4096; in_tag = 4'h9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("after_rst_valid", out_valid, 1);
    check("after_rst_dx", $signed(out_dx), 768);
    check("after_rst_tag", out_tag, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
